// File: rtl/paralelo_serial.sv
// -----------------------------------------------------------------------------
// paralelo_serial
//
// Parallel-to-serial transmitter for the serial link. Bytes enter through a
// one-deep valid/ready buffer and leave MSB-first, one bit per clk_32f cycle,
// on a fixed 8-cycle word frame. Frames with no data carry the COMMA word.
// After every reset, SYNC_WORDS commas are forced onto the line before any
// data is allowed out, so the receiver can lock to the word boundary.
//
// Handshake: a byte transfers at a rising edge of clk_32f where
// valid_in && ready_out. ready_out is high exactly while the buffer is empty.
// While ready_out is low, valid_in and data_in are ignored.
//
// Ports
//   clk_32f    in   bit clock, all flops on the rising edge
//   reset      in   asynchronous, active-low; clears all state immediately
//   data_in    in   [7:0] byte to transmit
//   valid_in   in   data_in is valid
//   ready_out  out  buffer empty, a byte can be accepted
//   data_out   out  serial stream, MSB first (top bit of the shift register)
//   sync_out   out  high once the alignment preamble is done; this is the
//                   FSM state (SYNC=0, ACTIVE=1) brought out for observation
//   frame_out  out  high while the MSB of a word is on data_out
// -----------------------------------------------------------------------------
module paralelo_serial #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_WORDS = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       sync_out,
  output logic       frame_out
);

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // comma_cnt value at the load edge that loads the final preamble comma
  localparam logic [3:0] LAST_SYNC = 4'(SYNC_WORDS - 1);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, shift_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] next_byte;
  logic       load;
  logic       accept;
  logic       drain;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SYNC;
      bit_cnt_q   <= 3'd7;  // so the first edge after release is a load edge
      shift_q     <= 8'h00;
      buf_q       <= 8'h00;
      buf_full_q  <= 1'b0;
      comma_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_q + 3'd1;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      comma_cnt_q <= comma_cnt_d;
    end
  end

  always_comb begin
    load   = (bit_cnt_q == 3'd7);
    accept = valid_in && !buf_full_q;
    // The buffer is only ever consumed in ACTIVE; in SYNC it simply waits.
    drain  = load && (state_q == ST_ACTIVE) && buf_full_q;

    next_byte = COMMA;
    if ((state_q == ST_ACTIVE) && buf_full_q) begin
      next_byte = buf_q;
    end

    shift_d = load ? next_byte : {shift_q[6:0], 1'b0};

    // accept needs an empty buffer, drain needs a full one: never both.
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (accept) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
    end else if (drain) begin
      buf_full_d = 1'b0;
    end

    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    if (load && (state_q == ST_SYNC)) begin
      comma_cnt_d = comma_cnt_q + 4'd1;
      if (comma_cnt_q == LAST_SYNC) begin
        state_d = ST_ACTIVE;
      end
    end
  end

  assign ready_out = !buf_full_q;
  assign data_out  = shift_q[7];
  assign sync_out  = (state_q == ST_ACTIVE);
  assign frame_out = (bit_cnt_q == 3'd0);

endmodule

// File: tb/tb_paralelo_serial.sv
// -----------------------------------------------------------------------------
// tb_paralelo_serial
//
// Directed bench for paralelo_serial. Cycle c means "just after the c-th
// rising edge following reset release"; outputs are sampled 1 time unit after
// each rising edge. Expected line contents are written as word lists, and bit
// (c-1)%8 of word (c-1)/8 (MSB first) is what data_out must show in cycle c.
// -----------------------------------------------------------------------------
module tb_paralelo_serial;

  logic       clk_32f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       sync_out;
  logic       frame_out;

  int n_vec;
  int n_err;
  int cyc;

  paralelo_serial dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .sync_out  (sync_out),
    .frame_out (frame_out)
  );

  // ---------------------------------------------------------------- clock
  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk_32f);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clk_32f);
    #1;
    reset = 1'b1;
    cyc   = 0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'h77;
    repeat (2) @(posedge clk_32f);
    #1;
    n_vec = n_vec + 1;
    if (data_out !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_data_out: got %b want 0", data_out);
    end
    n_vec = n_vec + 1;
    if (frame_out !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_frame_out: got %b want 0", frame_out);
    end
    n_vec = n_vec + 1;
    if (sync_out !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_sync_out: got %b want 0", sync_out);
    end
    n_vec = n_vec + 1;
    if (ready_out !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL reset_ready_out: got %b want 1", ready_out);
    end
  endtask

  task automatic test_idle();
    logic [7:0] w;
    int b;
    do_reset();
    w = 8'hBC;
    for (int c = 1; c <= 64; c++) begin
      step();
      b = (c - 1) % 8;
      n_vec = n_vec + 1;
      if (data_out !== w[7-b]) begin
        n_err = n_err + 1;
        $display("FAIL idle_data_out c=%0d: got %b want %b", c, data_out, w[7-b]);
      end
      n_vec = n_vec + 1;
      if (frame_out !== (b == 0)) begin
        n_err = n_err + 1;
        $display("FAIL idle_frame_out c=%0d: got %b want %b", c, frame_out, (b == 0));
      end
      n_vec = n_vec + 1;
      if (sync_out !== (c >= 25)) begin
        n_err = n_err + 1;
        $display("FAIL idle_sync_out c=%0d: got %b want %b", c, sync_out, (c >= 25));
      end
      n_vec = n_vec + 1;
      if (ready_out !== 1'b1) begin
        n_err = n_err + 1;
        $display("FAIL idle_ready_out c=%0d: got %b want 1", c, ready_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[$];
    logic [7:0] tx[$];
    logic [7:0] w;
    logic acc;
    int idx;
    words = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hFF, 8'hEE, 8'hBC};
    tx    = '{8'hFF, 8'hEE};
    idx   = 0;
    do_reset();
    for (int c = 1; c <= 56; c++) begin
      acc = valid_in && ready_out;
      step();
      if (acc) begin
        idx = idx + 1;
        if (idx < tx.size()) data_in = tx[idx];
        else valid_in = 1'b0;
      end
      // offer the first byte so it lands in the buffer at edge 32
      if (c == 31) begin
        valid_in = 1'b1;
        data_in  = tx[0];
      end
      w = words[(c - 1) / 8];
      n_vec = n_vec + 1;
      if (data_out !== w[7-((c-1)%8)]) begin
        n_err = n_err + 1;
        $display("FAIL b2b_data_out c=%0d: got %b want %b", c, data_out, w[7-((c-1)%8)]);
      end
    end
  endtask

  task automatic test_sync_offer();
    logic [7:0] words[$];
    logic [7:0] w;
    words = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC};
    do_reset();
    valid_in = 1'b1;
    data_in  = 8'h55;
    for (int c = 1; c <= 48; c++) begin
      step();
      if (c == 1) valid_in = 1'b0;
      w = words[(c - 1) / 8];
      n_vec = n_vec + 1;
      if (data_out !== w[7-((c-1)%8)]) begin
        n_err = n_err + 1;
        $display("FAIL sync_offer_data_out c=%0d: got %b want %b", c, data_out, w[7-((c-1)%8)]);
      end
      n_vec = n_vec + 1;
      if (ready_out !== (c >= 33)) begin
        n_err = n_err + 1;
        $display("FAIL sync_offer_ready_out c=%0d: got %b want %b", c, ready_out, (c >= 33));
      end
    end
  endtask

  // Continues from test_sync_offer: cycle 48, ACTIVE, buffer empty.
  task automatic test_accept_on_load();
    logic [7:0] words[$];
    logic [7:0] w;
    words = '{8'hBC, 8'h81, 8'hBC};
    valid_in = 1'b1;
    data_in  = 8'h81;
    for (int c = 49; c <= 72; c++) begin
      step();
      if (c == 49) begin
        valid_in = 1'b0;
        n_vec = n_vec + 1;
        if (ready_out !== 1'b0) begin
          n_err = n_err + 1;
          $display("FAIL load_accept_ready_out: got %b want 0", ready_out);
        end
      end
      w = words[(c - 49) / 8];
      n_vec = n_vec + 1;
      if (data_out !== w[7-((c-49)%8)]) begin
        n_err = n_err + 1;
        $display("FAIL load_accept_data_out c=%0d: got %b want %b", c, data_out, w[7-((c-49)%8)]);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] words[$];
    logic [7:0] tx[$];
    logic [7:0] w;
    logic acc;
    int idx;
    words = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5};
    tx    = '{8'hA5, 8'h3C};
    idx   = 0;
    do_reset();
    valid_in = 1'b1;
    data_in  = tx[0];
    // A5 loads at edge 33, 3C is buffered at edge 34; cycle 37 carries A5 bit 3.
    for (int c = 1; c <= 37; c++) begin
      acc = valid_in && ready_out;
      step();
      if (acc) begin
        idx = idx + 1;
        if (idx < tx.size()) data_in = tx[idx];
        else valid_in = 1'b0;
      end
      w = words[(c - 1) / 8];
      n_vec = n_vec + 1;
      if (data_out !== w[7-((c-1)%8)]) begin
        n_err = n_err + 1;
        $display("FAIL midreset_pre_data_out c=%0d: got %b want %b", c, data_out, w[7-((c-1)%8)]);
      end
    end
    n_vec = n_vec + 1;
    if (ready_out !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL midreset_buffered: ready_out got %b want 0", ready_out);
    end
    reset    = 1'b0;
    valid_in = 1'b0;
    #1;
    n_vec = n_vec + 1;
    if (data_out !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL midreset_data_out: got %b want 0", data_out);
    end
    n_vec = n_vec + 1;
    if (sync_out !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL midreset_sync_out: got %b want 0", sync_out);
    end
    n_vec = n_vec + 1;
    if (ready_out !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL midreset_ready_out: got %b want 1", ready_out);
    end
    n_vec = n_vec + 1;
    if (frame_out !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL midreset_frame_out: got %b want 0", frame_out);
    end
    do_reset();
    // 3C must be gone: four preamble commas, one idle comma, then 96
    // (accepted at edge 40, one cycle before load edge 41).
    words = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h96};
    for (int c = 1; c <= 48; c++) begin
      step();
      if (c == 39) begin
        valid_in = 1'b1;
        data_in  = 8'h96;
      end
      if (c == 40) valid_in = 1'b0;
      if (c <= 39) begin
        n_vec = n_vec + 1;
        if (ready_out !== 1'b1) begin
          n_err = n_err + 1;
          $display("FAIL midreset_post_ready_out c=%0d: got %b want 1", c, ready_out);
        end
      end
      w = words[(c - 1) / 8];
      n_vec = n_vec + 1;
      if (data_out !== w[7-((c-1)%8)]) begin
        n_err = n_err + 1;
        $display("FAIL midreset_post_data_out c=%0d: got %b want %b", c, data_out, w[7-((c-1)%8)]);
      end
    end
  endtask

  // Continues from test_reset_mid_byte: cycle 48, ACTIVE, buffer empty.
  task automatic test_backpressure();
    logic [7:0] words[$];
    logic [7:0] tx[$];
    logic [7:0] w;
    logic acc;
    int idx;
    words = '{8'hBC, 8'h11, 8'h22, 8'h33, 8'hBC};
    tx    = '{8'h11, 8'h22, 8'h33};
    idx   = 0;
    valid_in = 1'b1;
    data_in  = tx[0];
    for (int c = 49; c <= 88; c++) begin
      acc = valid_in && ready_out;
      step();
      if (acc) begin
        idx = idx + 1;
        if (idx < tx.size()) data_in = tx[idx];
        else valid_in = 1'b0;
      end
      w = words[(c - 49) / 8];
      n_vec = n_vec + 1;
      if (data_out !== w[7-((c-49)%8)]) begin
        n_err = n_err + 1;
        $display("FAIL backpressure_data_out c=%0d: got %b want %b", c, data_out, w[7-((c-49)%8)]);
      end
    end
    n_vec = n_vec + 1;
    if (idx != 3) begin
      n_err = n_err + 1;
      $display("FAIL backpressure_accepts: got %0d want 3", idx);
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    n_vec    = 0;
    n_err    = 0;
    cyc      = 0;
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    test_reset();
    test_idle();
    test_back_to_back();
    test_sync_offer();
    test_accept_on_load();
    test_reset_mid_byte();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/paralelo_serial.md
# paralelo_serial

Parallel-to-serial transmitter for the serial link: the send-side counterpart of the serial-to-parallel receiver. It accepts bytes through a one-deep valid/ready buffer. Each byte is shifted out MSB-first, one bit per `clk_32f` cycle, on an 8-cycle word frame. Idle frames are filled with the comma word 0xBC. After every reset, SYNC_WORDS commas are sent before any data so the receiver can lock to the word boundary.

## Interface
- `COMMA`, 8'hBC, idle/alignment word
- `SYNC_WORDS`, 4, commas forced after reset before data is allowed (range 1–15)
- `clk_32f`  input  1  bit clock; all flops on rising edge
- `reset`  input  1  asynchronous, active-low; low clears all state immediately
- `data_in`  input  8  byte to transmit
- `valid_in`  input  1  `data_in` is valid
- `ready_out`  output  1  buffer empty; transfer occurs at a rising edge with `valid_in && ready_out`
- `data_out`  output  1  serial bit stream, MSB first; driven directly from `shift_reg[7]`
- `sync_out`  output  1  high once the alignment preamble is complete (ACTIVE state)
- `frame_out`  output  1  high while the MSB of a word is on `data_out`

## Operation
- Registers:
  - `bit_cnt` [2:0], wraps 7→0
  - `shift_reg` [7:0]
  - `buf` [7:0] and `buf_full`
  - `comma_cnt` [3:0]
  - state: SYNC or ACTIVE
- Load edge: a rising edge with `bit_cnt == 7`.
  - On a load edge, `shift_reg <= next_byte`.
  - On any other edge, `shift_reg <= {shift_reg[6:0], 1'b0}`.
  - `bit_cnt` increments on every edge.
- `next_byte` selection:
  - SYNC: always COMMA. `buf` is never consumed in SYNC.
  - ACTIVE with `buf_full`: `buf`; `buf_full` clears on the same edge.
  - ACTIVE with `buf` empty: COMMA (idle fill).
- SYNC→ACTIVE:
  - Every load edge in SYNC increments `comma_cnt`.
  - The load edge that loads the SYNC_WORDS-th comma sets the state to ACTIVE.
  - ACTIVE has no exit except reset.
- Buffer:
  - `ready_out = !buf_full`. Accepts are allowed in either state.
  - On accept: `buf <= data_in`, `buf_full <= 1`.
  - While `ready_out` is 0, `valid_in` and `data_in` are ignored.
  - Accept and drain cannot coincide: an accept requires `buf` empty, a drain requires `buf_full`.
- Outputs:
  - `sync_out = (state == ACTIVE)`.
  - `frame_out = (bit_cnt == 0)`.

## Timing
- Reset values (asserted asynchronously):
  - `bit_cnt = 7`, `shift_reg = 0`
  - `buf_full = 0`, `buf = 0`, `comma_cnt = 0`, state SYNC
  - Outputs: `data_out = 0`, `frame_out = 0`, `sync_out = 0`, `ready_out = 1`
- First rising edge after `reset` goes high is a load edge:
  - First comma MSB (1) on `data_out` in cycle 1 after that edge, with `frame_out = 1`.
  - Word bits appear in order 1,0,1,1,1,1,0,0.
- `sync_out` rises at the SYNC_WORDS-th load edge, i.e. while the last preamble comma is on the line. With default parameters this is the 4th load edge, cycles 25–32.
- The first data byte can start at load edge SYNC_WORDS+1 (cycle 33 with defaults).
- Latency, accept edge to MSB on `data_out` (ACTIVE, `buf` empty):
  - 1 cycle if accepted at the edge just before a load edge.
  - 8 cycles if accepted at a load edge, because that edge loads the old `buf` state.
- Throughput: one byte per 8 cycles. With `valid_in` held high, back-to-back bytes go out with no idle commas between them.
- Reset mid-word:
  - Serialization aborts at once and the partial word is truncated.
  - Buffered data is discarded.
  - The full SYNC_WORDS preamble is resent after release.
- `data_out` changes only on rising edges of `clk_32f`, except for the asynchronous clear.

## Test plan
- **Reset then idle:** release reset with `valid_in = 0` for 64 cycles. Required: `data_out` repeats 10111100 eight times; `frame_out` pulses every 8 cycles on each leading 1; `sync_out` goes high at cycle 25 and stays high; `ready_out = 1` throughout.
- **Back-to-back data after sync:** present 0xFF then 0xEE, each accepted as soon as `ready_out` allows, from cycle 33. Required: `data_out` carries 11111111, then 11101110, then 10111100 idle; no comma between the two bytes.
- **Data offered during SYNC:** at the first edge after reset, present 0x55 with `valid_in` held. Required: the byte is accepted at the first edge; `ready_out = 0` until load edge 5; 0x55 (01010101) is the 5th word on the line, after exactly four commas.
- **Accept on a load edge:** in ACTIVE with `buf` empty, accept 0x81 at a load edge. Required: that word is a comma; 10000001 starts exactly 8 cycles later.
- **Reset mid-byte:** assert `reset` at bit 3 of 0xA5 while 0x3C is buffered. Required: `data_out = 0` immediately, with `sync_out = 0` and `ready_out = 1`; 0x3C is never transmitted; four commas precede the next data.
- **Backpressure:** hold `valid_in` high with changing `data_in` (0x11, 0x22, 0x33, updated only on accept edges). Required: each value is transmitted exactly once, in order, with no loss or duplication.
